// File: rtl/doorlock_ctrl.sv
// Passcode door-lock controller: collects keypad digits, checks them against a
// stored code, drives the actuator/alarm and allows code change while open.
module doorlock_ctrl #(
  parameter int unsigned                CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0]      DEFAULT_CODE   = 16'h1234,
  parameter int unsigned                UNLOCK_CYCLES  = 50_000_000,
  parameter int unsigned                LOCKOUT_CYCLES = 250_000_000,
  parameter int unsigned                MAX_FAILS      = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] mode_i,
  input  logic [3:0] num_i,
  output logic       unlock_o,
  output logic       alarm_o,
  output logic [2:0] state_o,
  output logic [3:0] digit_cnt_o,
  output logic [1:0] fail_cnt_o,
  output logic       code_set_o
);

  localparam int unsigned CW   = 4 * CODE_LEN;
  localparam int unsigned TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_CHECK   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_SET     = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   entry_q, entry_d;
  logic [CW-1:0]   code_q, code_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [1:0]      fail_q, fail_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            prev_valid_q;
  logic            code_set_q, code_set_d;
  logic            unlock_q, alarm_q;

  logic            key_valid;
  logic            ev_digit, ev_clear, ev_enter;
  logic            code_match;
  logic [2:0]      fail_inc;
  logic [TW-1:0]   timer_dec;

  // One event per press: a valid key counts only when the previous cycle was idle
  always_comb begin
    key_valid = ((mode_i == 2'd0) && (num_i <= 4'd9)) ||
                (((mode_i == 2'd1) || (mode_i == 2'd2)) && (num_i == 4'd0));
    ev_digit  = key_valid && !prev_valid_q && (mode_i == 2'd0);
    ev_clear  = key_valid && !prev_valid_q && (mode_i == 2'd1);
    ev_enter  = key_valid && !prev_valid_q && (mode_i == 2'd2);
  end

  always_comb begin
    code_match = (cnt_q == 4'(CODE_LEN)) && (entry_q == code_q);
    fail_inc   = {1'b0, fail_q} + 3'd1;
    timer_dec  = (timer_q != '0) ? timer_q - TW'(1) : '0;
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    cnt_d      = cnt_q;
    fail_d     = fail_q;
    timer_d    = timer_q;
    code_d     = code_q;
    code_set_d = 1'b0;

    case (state_q)
      ST_ENTRY, ST_SET: begin
        if (ev_digit) begin
          if (cnt_q < 4'(CODE_LEN)) begin
            entry_d = (entry_q << 4) | CW'(num_i);
            cnt_d   = cnt_q + 4'd1;
          end
        end else if (ev_clear) begin
          entry_d = '0;
          cnt_d   = '0;
          if (state_q == ST_SET) state_d = ST_ENTRY;
        end else if (ev_enter) begin
          if (state_q == ST_ENTRY) begin
            state_d = ST_CHECK;
          end else begin
            if (cnt_q == 4'(CODE_LEN)) begin
              code_d     = entry_q;
              code_set_d = 1'b1;
            end
            entry_d = '0;
            cnt_d   = '0;
            state_d = ST_ENTRY;
          end
        end
      end

      ST_CHECK: begin
        entry_d = '0;
        cnt_d   = '0;
        if (code_match) begin
          state_d = ST_OPEN;
          timer_d = TW'(UNLOCK_CYCLES);
          fail_d  = '0;
        end else begin
          fail_d = 2'(fail_inc);
          if (fail_inc == 3'(MAX_FAILS)) begin
            state_d = ST_LOCKOUT;
            timer_d = TW'(LOCKOUT_CYCLES);
          end else begin
            state_d = ST_ENTRY;
          end
        end
      end

      ST_OPEN: begin
        if (ev_enter) begin
          state_d = ST_ENTRY;
          timer_d = '0;
        end else if (ev_clear) begin
          state_d = ST_SET;
          timer_d = '0;
        end else begin
          timer_d = timer_dec;
          if (timer_q <= TW'(1)) state_d = ST_ENTRY;
        end
      end

      ST_LOCKOUT: begin
        timer_d = timer_dec;
        if (timer_q <= TW'(1)) begin
          state_d = ST_ENTRY;
          fail_d  = '0;
        end
      end

      default: begin
        state_d = ST_ENTRY;
        entry_d = '0;
        cnt_d   = '0;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_ENTRY;
      entry_q      <= '0;
      cnt_q        <= '0;
      fail_q       <= '0;
      timer_q      <= '0;
      code_q       <= DEFAULT_CODE;
      prev_valid_q <= 1'b0;
      code_set_q   <= 1'b0;
      unlock_q     <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      entry_q      <= entry_d;
      cnt_q        <= cnt_d;
      fail_q       <= fail_d;
      timer_q      <= timer_d;
      code_q       <= code_d;
      prev_valid_q <= key_valid;
      code_set_q   <= code_set_d;
      unlock_q     <= (state_d == ST_OPEN);
      alarm_q      <= (state_d == ST_LOCKOUT);
    end
  end

  assign unlock_o    = unlock_q;
  assign alarm_o     = alarm_q;
  assign state_o     = state_q;
  assign digit_cnt_o = cnt_q;
  assign fail_cnt_o  = fail_q;
  assign code_set_o  = code_set_q;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Bench for doorlock_ctrl: directed test-plan scenarios plus random key traffic,
// every cycle compared against a digit-queue / decimal-code reference model.
module tb_doorlock_ctrl;

  localparam int UNLOCK_N  = 8;
  localparam int LOCKOUT_N = 16;
  localparam int FAILS_N   = 3;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [1:0] mode_i;
  logic [3:0] num_i;
  logic       unlock_o, alarm_o, code_set_o;
  logic [2:0] state_o;
  logic [3:0] digit_cnt_o;
  logic [1:0] fail_cnt_o;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: buffer as a digit queue, stored code as a decimal number
  int m_st;
  int m_buf[$];
  int m_code;
  bit m_prev;
  int m_fails;
  int m_left;
  bit m_set;

  int unlock_cnt, alarm_cnt, set_cnt;

  doorlock_ctrl #(
    .CODE_LEN       (4),
    .DEFAULT_CODE   (16'h1234),
    .UNLOCK_CYCLES  (UNLOCK_N),
    .LOCKOUT_CYCLES (LOCKOUT_N),
    .MAX_FAILS      (FAILS_N)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .mode_i      (mode_i),
    .num_i       (num_i),
    .unlock_o    (unlock_o),
    .alarm_o     (alarm_o),
    .state_o     (state_o),
    .digit_cnt_o (digit_cnt_o),
    .fail_cnt_o  (fail_cnt_o),
    .code_set_o  (code_set_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int buf_value();
    int v = 0;
    foreach (m_buf[i]) v = v * 10 + m_buf[i];
    return v;
  endfunction

  task automatic model_reset();
    m_st = 0;
    m_buf.delete();
    m_code = 1234;
    m_prev = 1'b0;
    m_fails = 0;
    m_left = 0;
    m_set = 1'b0;
  endtask

  task automatic model_step(input int m, input int n);
    bit valid, ev, dig, clr, ent;
    valid  = (m == 0 && n <= 9) || ((m == 1 || m == 2) && n == 0);
    ev     = valid && !m_prev;
    m_prev = valid;
    m_set  = 1'b0;
    dig = ev && (m == 0);
    clr = ev && (m == 1);
    ent = ev && (m == 2);
    case (m_st)
      0, 3: begin
        if (dig) begin
          if (m_buf.size() < 4) m_buf.push_back(n);
        end else if (clr) begin
          m_buf.delete();
          m_st = 0;
        end else if (ent) begin
          if (m_st == 0) begin
            m_st = 1;
          end else begin
            if (m_buf.size() == 4) begin
              m_code = buf_value();
              m_set  = 1'b1;
            end
            m_buf.delete();
            m_st = 0;
          end
        end
      end
      1: begin
        if (m_buf.size() == 4 && buf_value() == m_code) begin
          m_st = 2;
          m_left = UNLOCK_N;
          m_fails = 0;
        end else begin
          m_fails++;
          if (m_fails == FAILS_N) begin
            m_st = 4;
            m_left = LOCKOUT_N;
          end else begin
            m_st = 0;
          end
        end
        m_buf.delete();
      end
      2: begin
        if (ent) m_st = 0;
        else if (clr) m_st = 3;
        else begin
          m_left--;
          if (m_left <= 0) m_st = 0;
        end
      end
      4: begin
        m_left--;
        if (m_left <= 0) begin
          m_st = 0;
          m_fails = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("state",     32'(state_o),     32'(m_st));
    chk("unlock",    32'(unlock_o),    32'(m_st == 2));
    chk("alarm",     32'(alarm_o),     32'(m_st == 4));
    chk("digit_cnt", 32'(digit_cnt_o), 32'(m_buf.size()));
    chk("fail_cnt",  32'(fail_cnt_o),  32'(m_fails));
    chk("code_set",  32'(code_set_o),  32'(m_set));
  endtask

  task automatic tick(input int m, input int n);
    mode_i = 2'(m);
    num_i  = 4'(n);
    @(posedge clk_i);
    model_step(m, n);
    #1;
    check_all();
    if (unlock_o === 1'b1) unlock_cnt++;
    if (alarm_o === 1'b1) alarm_cnt++;
    if (code_set_o === 1'b1) set_cnt++;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick(3, 10);
  endtask

  task automatic press(input int m, input int n, input int hold, input int gap);
    for (int i = 0; i < hold; i++) tick(m, n);
    idle(gap);
  endtask

  task automatic digit(input int d);
    press(0, d, 3, 2);
  endtask

  task automatic clear_key();
    press(1, 0, 3, 2);
  endtask

  task automatic enter_key();
    press(2, 0, 3, 2);
  endtask

  task automatic code4(input int a, input int b, input int c, input int d);
    digit(a); digit(b); digit(c); digit(d);
  endtask

  // Asynchronous reset between clock edges; outputs must clear before any edge
  task automatic async_reset();
    rst_i = 1'b0;
    #1;
    chk("rst_unlock",    32'(unlock_o),    32'd0);
    chk("rst_alarm",     32'(alarm_o),     32'd0);
    chk("rst_state",     32'(state_o),     32'd0);
    chk("rst_digit_cnt", 32'(digit_cnt_o), 32'd0);
    chk("rst_fail_cnt",  32'(fail_cnt_o),  32'd0);
    chk("rst_code_set",  32'(code_set_o),  32'd0);
    model_reset();
    #1;
    rst_i = 1'b1;
  endtask

  initial begin
    rst_i  = 1'b0;
    mode_i = 2'd3;
    num_i  = 4'd10;
    model_reset();
    unlock_cnt = 0;
    alarm_cnt  = 0;
    set_cnt    = 0;
    repeat (2) @(posedge clk_i);
    #1;
    check_all();
    rst_i = 1'b1;

    // Correct code opens for exactly UNLOCK_N cycles
    unlock_cnt = 0;
    code4(1, 2, 3, 4);
    enter_key();
    idle(12);
    chk("unlock_len", 32'(unlock_cnt), 32'(UNLOCK_N));

    // Three wrong codes trigger lockout; keys ignored during it
    alarm_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      code4(1, 2, 3, 5);
      enter_key();
    end
    digit(1);
    digit(2);
    idle(12);
    chk("alarm_len", 32'(alarm_cnt), 32'(LOCKOUT_N));

    // Held key counts once; buffer saturates keeping the first digits
    press(0, 7, 10, 2);
    code4(1, 2, 3, 4);
    digit(5);
    digit(6);
    clear_key();
    code4(1, 2, 3, 4);
    digit(5);
    digit(6);
    enter_key();
    idle(10);

    // Short code in SET leaves stored code unchanged
    set_cnt = 0;
    code4(1, 2, 3, 4);
    enter_key();
    idle(2);
    clear_key();
    digit(5);
    digit(5);
    enter_key();
    chk("no_code_set", 32'(set_cnt), 32'd0);
    code4(1, 2, 3, 4);
    enter_key();
    idle(10);

    // Code change to 9876, old code then fails, new one opens; early relock
    set_cnt = 0;
    code4(1, 2, 3, 4);
    enter_key();
    clear_key();
    code4(9, 8, 7, 6);
    enter_key();
    chk("code_set_pulses", 32'(set_cnt), 32'd1);
    code4(1, 2, 3, 4);
    enter_key();
    idle(2);
    unlock_cnt = 0;
    code4(9, 8, 7, 6);
    enter_key();
    press(2, 0, 1, 3);
    chk("relock_len", 32'(unlock_cnt), 32'd4);
    idle(6);

    // Reset mid-entry and mid-open; reset restores the default code
    digit(1);
    digit(2);
    async_reset();
    code4(1, 2, 3, 4);
    enter_key();
    async_reset();
    code4(1, 2, 3, 4);
    enter_key();
    clear_key();
    code4(4, 4, 0, 1);
    enter_key();
    async_reset();
    unlock_cnt = 0;
    code4(1, 2, 3, 4);
    enter_key();
    idle(10);
    chk("default_after_rst", 32'(unlock_cnt), 32'(UNLOCK_N));

    // Random key traffic against the model
    for (int it = 0; it < 400; it++) begin
      int r;
      r = int'($urandom_range(0, 11));
      if (it == 200) async_reset();
      if (r <= 4) begin
        press(0, int'($urandom_range(0, 9)), int'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
      end else if (r == 5) begin
        press(1, 0, int'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
      end else if (r == 6) begin
        press(2, 0, int'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
      end else if (r == 7) begin
        tick(int'($urandom_range(0, 3)), int'($urandom_range(1, 15)));
      end else if (r <= 9) begin
        int c;
        c = m_code;
        digit((c / 1000) % 10);
        digit((c / 100) % 10);
        digit((c / 10) % 10);
        digit(c % 10);
        if ($urandom_range(0, 1) == 1) enter_key();
      end else begin
        idle(int'($urandom_range(1, 6)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/doorlock_ctrl.md
# doorlock_ctrl

Passcode controller consuming the decoded key stream (`mode`/`num`) produced by the keypad number interface. It collects digit presses into an entry buffer, compares the buffer against a stored code on ENTER, drives the lock/alarm outputs, and lets the user change the code while the door is open. It sits directly downstream of the keypad decoder and is the only block that drives the door actuator.

## Interface
- `CODE_LEN`, 4, digits per passcode (1..8)
- `DEFAULT_CODE`, 16'h1234, reset value of the stored code; 4 bits per digit, BCD, MS digit first
- `UNLOCK_CYCLES`, 50_000_000, cycles `unlock_o` stays high
- `LOCKOUT_CYCLES`, 250_000_000, cycles of alarm lockout
- `MAX_FAILS`, 3, consecutive failed checks that trigger lockout

- `clk_i`  in  1  system clock
- `rst_i`  in  1  asynchronous, active-low reset
- `mode_i`  in  2  key class: 0 = digit, 1 = CLEAR, 2 = ENTER, 3 = idle/invalid
- `num_i`  in  4  digit value 0..9 when `mode_i`=0; 10 = idle code
- `unlock_o`  out  1  door actuator enable
- `alarm_o`  out  1  lockout indicator
- `state_o`  out  3  current FSM state encoding
- `digit_cnt_o`  out  4  digits currently held in entry buffer
- `fail_cnt_o`  out  2  consecutive failed checks
- `code_set_o`  out  1  one-cycle pulse when a new code is stored

## Operation
- Input classification: valid key = (`mode_i`=0 and `num_i`≤9) or (`mode_i`=1 and `num_i`=0) or (`mode_i`=2 and `num_i`=0); anything else is idle.
- Press event: current input valid AND previous-cycle registered input idle. A held key produces exactly one event; the key must return to idle before the next event is accepted. Valid→different-valid with no idle gap produces no event.
- The previous-input register resets to idle.
- States: ENTRY=0, CHECK=1, OPEN=2, SET=3, LOCKOUT=4.
- ENTRY: digit event with cnt<CODE_LEN → `entry <= {entry, num}` (shift left 4), cnt+1; digit with cnt=CODE_LEN is ignored. CLEAR → entry=0, cnt=0. ENTER → CHECK.
- CHECK (single cycle): match iff cnt=CODE_LEN and entry=stored code.
  - Match → OPEN, timer=UNLOCK_CYCLES, fail_cnt=0.
  - Mismatch → fail_cnt+1; if the new value = MAX_FAILS → LOCKOUT, timer=LOCKOUT_CYCLES; else → ENTRY.
  - Entry buffer and cnt are cleared on every exit from CHECK.
- OPEN: `unlock_o`=1; timer decrements each cycle; → ENTRY when the timer reaches 0. ENTER event → ENTRY immediately (manual relock). CLEAR event → SET; `unlock_o` drops.
- SET: digit handling is identical to ENTRY.
  - ENTER with cnt=CODE_LEN → stored code <= entry, `code_set_o` pulses, → ENTRY.
  - ENTER with cnt<CODE_LEN → stored code unchanged, → ENTRY.
  - CLEAR → abort, → ENTRY.
  - SET has no timeout. Buffer is cleared on exit.
- LOCKOUT: `alarm_o`=1; all key events are ignored; timer decrements; at 0 → ENTRY with fail_cnt=0.
- A successful check resets fail_cnt. A manual relock or code change does not alter fail_cnt.
- Timer width: `$clog2(max(UNLOCK_CYCLES, LOCKOUT_CYCLES)+1)`. Timer never wraps below 0.

## Timing
- All outputs are registered. Reset values: `unlock_o`=0, `alarm_o`=0, `state_o`=0 (ENTRY), `digit_cnt_o`=0, `fail_cnt_o`=0, `code_set_o`=0; stored code = DEFAULT_CODE; timer = 0.
- An event present before edge N is applied at edge N; the updated cnt/state is visible after N.
- ENTER applied at edge E → state CHECK after E → OPEN or ENTRY or LOCKOUT after E+1. `unlock_o` rises after E+1.
- `unlock_o` is high for exactly UNLOCK_CYCLES cycles (no early ENTER). `alarm_o` is high for exactly LOCKOUT_CYCLES cycles.
- CHECK ignores input: an event arriving during the CHECK cycle is lost.
- `code_set_o` is high for exactly the cycle after the storing edge.
- Reset assertion mid-operation: all state returns to reset values immediately (async), and any code programmed in SET is lost (stored code reverts to DEFAULT_CODE).

## Test plan
Benches use CODE_LEN=4, DEFAULT_CODE=16'h1234, UNLOCK_CYCLES=8, LOCKOUT_CYCLES=16, MAX_FAILS=3.
- Press 1,2,3,4 (each held 3 cycles, 2 idle cycles between), then ENTER → `state_o` 1 then 2; `unlock_o` high exactly 8 cycles; `fail_cnt_o`=0.
- Press 1,2,3,5,ENTER three times → `fail_cnt_o` 1, 2; after the third ENTER, `alarm_o` high 16 cycles; digit presses during lockout leave `digit_cnt_o`=0; then ENTRY with `fail_cnt_o`=0.
- Hold digit 7 for 10 cycles → `digit_cnt_o`=1. Press 1..6 (six digits) → cnt saturates at 4, buffer holds the first four digits. CLEAR → cnt=0.
- Unlock, press CLEAR (→ SET), press 9,8,7,6,ENTER → `code_set_o` single pulse. 1234+ENTER now fails; 9876+ENTER unlocks.
- In SET, press 5,5,ENTER → stored code unchanged and 1234 still unlocks. In OPEN, ENTER at cycle 3 → `unlock_o` drops after 3 cycles.
- Assert `rst_i` low mid-entry (cnt=2) and mid-OPEN → all outputs go to 0 asynchronously; after a code change followed by reset, 1234 unlocks again.
